// File: rtl/ff_ls_math_cell.sv
// ff_ls_math_cell
//   Three independent functions that share one clock and one reset:
//     * a single D flip-flop with synchronous active-low clear,
//     * an isolating level shifter (purely combinational),
//     * an unsigned ripple-carry adder (purely combinational).
//   Reset and clock touch only the flip-flop. The shifter and the adder are
//   not affected by either.
//
// Ports
//   clk         in   1      sole clock, rising edge
//   reset       in   1      synchronous clear of q, active low
//   d           in   1      flip-flop data
//   q           out  1      flip-flop output, one cycle after d
//   in_signal   in   WIDTH  level-shifter input (source domain)
//   iso_en      in   1      isolation enable, active high
//   out_signal  out  WIDTH  in_signal, or ISO_VALUE while isolated
//   a, b        in   WIDTH  unsigned adder operands
//   sum         out  WIDTH  low WIDTH bits of a+b
//   carry_out   out  1      bit WIDTH of a+b
module ff_ls_math_cell #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      ISO_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  output logic             q,
  input  logic [WIDTH-1:0] in_signal,
  input  logic             iso_en,
  output logic [WIDTH-1:0] out_signal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // ---------------------------------------------------------------------
  // Flip-flop: the only state element in the block.
  // ---------------------------------------------------------------------
  logic q_q;
  logic q_d;

  // Clear is taken only at a rising edge; between edges q holds.
  assign q_d = reset ? d : 1'b0;

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

  // ---------------------------------------------------------------------
  // Level shifter: while isolated the output is forced to ISO_VALUE, so
  // an undriven or unknown source domain never reaches the destination.
  // ---------------------------------------------------------------------
  assign out_signal = iso_en ? ISO_VALUE : in_signal;

  // ---------------------------------------------------------------------
  // Math cell: WIDTH full-adder stages chained LSB to MSB. The carry is a
  // procedural variable so the chain is one straight dependency path.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  always_comb begin
    logic c;
    c     = 1'b0;
    sum_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_d[i] = a[i] ^ b[i] ^ c;
      c        = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    carry_d = c;
  end

  assign sum       = sum_d;
  assign carry_out = carry_d;

endmodule

// File: tb/tb_ff_ls_math_cell.sv
module tb_ff_ls_math_cell;
  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         d;
  logic         q;
  logic [W-1:0] in_signal;
  logic         iso_en;
  logic [W-1:0] out_signal;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  ff_ls_math_cell #(.WIDTH(W), .ISO_VALUE({W{1'b0}})) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .q          (q),
    .in_signal  (in_signal),
    .iso_en     (iso_en),
    .out_signal (out_signal),
    .a          (a),
    .b          (b),
    .sum        (sum),
    .carry_out  (carry_out)
  );

  // driver / check helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: plain integer addition and the isolation rule
  function automatic logic [31:0] add_ref(input int x, input int y);
    return 32'(x + y);
  endfunction

  function automatic logic [31:0] ls_ref(input logic [W-1:0] s, input logic iso);
    return iso ? 32'(0) : 32'(s);
  endfunction

  // scoreboard: expected q values, one per clock edge
  logic [0:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; d = 1'b1; in_signal = '0; iso_en = 1'b0; a = '0; b = '0;

    // reset held for two edges with d=1
    step(); step();
    chk("reset_q", {31'b0, q}, 32'(0));
    reset = 1'b1; d = 1'b1;
    step();
    chk("load_one", {31'b0, q}, 32'(1));
    d = 1'b0;
    step();
    chk("load_zero", {31'b0, q}, 32'(0));
    d = 1'b1;
    step();
    chk("load_one_again", {31'b0, q}, 32'(1));

    // mid-cycle reset: no effect until the next edge; comb paths keep tracking
    #2;
    reset = 1'b0; a = 8'h12; b = 8'h34; in_signal = 8'h5A; iso_en = 1'b0;
    #1;
    chk("mid_reset_hold", {31'b0, q}, 32'(1));
    chk("mid_reset_sum", {23'b0, carry_out, sum}, add_ref(8'h12, 8'h34));
    chk("mid_reset_ls", 32'(out_signal), 32'(8'h5A));
    step();
    chk("mid_reset_clear", {31'b0, q}, 32'(0));
    chk("reset_ls", 32'(out_signal), 32'(8'h5A));
    reset = 1'b1;

    // directed adder cases
    a = 8'hAA; b = 8'h55; #1; chk("add_aa_55", {23'b0, carry_out, sum}, 32'h0FF);
    a = 8'h00; b = 8'h00; #1; chk("add_00_00", {23'b0, carry_out, sum}, 32'h000);
    a = 8'hFF; b = 8'h01; #1; chk("add_ff_01", {23'b0, carry_out, sum}, 32'h100);
    a = 8'hFF; b = 8'hFF; #1; chk("add_ff_ff", {23'b0, carry_out, sum}, 32'h1FE);
    a = 8'h80; b = 8'h80; #1; chk("add_80_80", {23'b0, carry_out, sum}, 32'h100);

    // directed level shifter cases
    in_signal = 8'hAA; iso_en = 1'b0; #1; chk("ls_pass_aa", 32'(out_signal), 32'h0AA);
    iso_en = 1'b1; #1; chk("ls_iso_aa", 32'(out_signal), 32'h000);
    in_signal = 'x; #1; chk("ls_iso_x", 32'(out_signal), 32'h000);
    in_signal = 8'h3C; iso_en = 1'b0; #1; chk("ls_pass_3c", 32'(out_signal), 32'h03C);

    // randomized: all three functions driven together each cycle
    for (int n = 0; n < 300; n++) begin
      int ai, bi;
      logic [W-1:0] s;
      logic iso;
      reset = ($urandom_range(0, 7) != 0);
      d     = 1'($urandom_range(0, 1));
      exp_q.push_back(reset ? d : 1'b0);
      ai = $urandom_range(0, 255); bi = $urandom_range(0, 255);
      s  = W'($urandom_range(0, 255)); iso = 1'($urandom_range(0, 1));
      a = W'(ai); b = W'(bi); in_signal = s; iso_en = iso;
      #1;
      chk("rand_add", {23'b0, carry_out, sum}, add_ref(ai, bi));
      chk("rand_ls", 32'(out_signal), ls_ref(s, iso));
      step();
      chk("rand_q", {31'b0, q}, {31'b0, exp_q.pop_front()});
    end
    reset = 1'b1;

    // exhaustive adder sweep, combinational only
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        a = W'(ai); b = W'(bi);
        #1;
        chk("exh_add", {23'b0, carry_out, sum}, add_ref(ai, bi));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ff_ls_math_cell.md
FF_LS_MATH_CELL -- requirements
Module: ff_ls_math_cell

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of the level-shifter and math-cell paths.
REQ-002 The block SHALL have parameter ISO_VALUE, default all-zeros (WIDTH bits), giving the value driven on out_signal while isolated.
REQ-003 Clocking and reset SHALL be one clock with a synchronous, active-low reset.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-006 Port d  input  1  flip-flop data input.
REQ-007 Port q  output  1  flip-flop registered output.
REQ-008 Port in_signal  input  WIDTH  level-shifter input, source domain.
REQ-009 Port iso_en  input  1  level-shifter isolation enable, active-high.
REQ-010 Port out_signal  output  WIDTH  level-shifter output, destination domain.
REQ-011 Port a  input  WIDTH  math-cell operand A, unsigned.
REQ-012 Port b  input  WIDTH  math-cell operand B, unsigned.
REQ-013 Port sum  output  WIDTH  math-cell sum, lower WIDTH bits of a+b.
REQ-014 Port carry_out  output  1  math-cell carry, bit WIDTH of a+b.

Function
REQ-015 Flip-flop: at each rising clk edge with reset=1, q SHALL take the value of d; latency is one cycle.
REQ-016 Flip-flop: at a rising clk edge with reset=0, q SHALL become 0 regardless of d.
REQ-017 Flip-flop: reset SHALL have no effect between clock edges (no asynchronous clear); q holds its value until the next rising edge.
REQ-018 Level shifter: out_signal SHALL be combinational, with no clock dependency.
REQ-019 Level shifter: out_signal SHALL equal in_signal bit-for-bit when iso_en=0.
REQ-020 Level shifter: out_signal SHALL equal ISO_VALUE when iso_en=1, independent of in_signal, including X or Z on in_signal.
REQ-021 Level shifter: out_signal SHALL be unaffected by reset.
REQ-022 Math cell: {carry_out, sum} SHALL equal the unsigned (WIDTH+1)-bit sum a+b, combinationally, with zero cycle latency.
REQ-023 Math cell: the adder SHALL be a ripple-carry chain of WIDTH full-adder stages; bit 0 has carry-in 0, and carry_out is the carry out of stage WIDTH-1.
REQ-024 Math cell: overflow SHALL wrap, so sum holds the low WIDTH bits and carry_out=1 exactly when a+b >= 2^WIDTH.
REQ-025 Math cell: the outputs SHALL be unaffected by reset and clk.
REQ-026 The three functions SHALL be independent; no output depends on another function's inputs.
REQ-027 The block SHALL contain no latches, and q SHALL be the only sequential element.

Reset
REQ-028 While reset=0 across a rising edge, q SHALL be 0 after that edge.
REQ-029 Before the first rising edge, q SHALL be unknown; benches SHALL hold reset=0 for at least one edge.
REQ-030 Deasserting reset SHALL take effect at the next rising edge; the first edge sampled with reset=1 loads d.
REQ-031 Asserting reset mid-operation SHALL clear q at the next rising edge, while out_signal, sum and carry_out continue tracking their inputs.

Verification
REQ-032 Reset: reset=0, d=1 for 2 edges -> q=0; then reset=1, d=1, one edge -> q=1; then d=0, one edge -> q=0.
REQ-033 Mid-operation reset: q=1, then reset=0 asserted between edges -> q stays 1 until the next rising edge, then q=0.
REQ-034 Add, no carry: a=8'hAA, b=8'h55 -> sum=8'hFF, carry_out=0; a=8'h00, b=8'h00 -> sum=8'h00, carry_out=0.
REQ-035 Add with wrap: a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1; a=8'hFF, b=8'hFF -> sum=8'hFE, carry_out=1; a=8'h80, b=8'h80 -> sum=8'h00, carry_out=1.
REQ-036 Level shifter: iso_en=0 with in_signal=8'hAA -> out_signal=8'hAA; iso_en=1 -> out_signal=8'h00; in_signal=8'hXX with iso_en=1 -> out_signal=8'h00.
REQ-037 Exhaustive: all 65536 (a,b) pairs at WIDTH=8 -> {carry_out, sum} equals a+b, with no cycle delay.
